// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 2-entry skid buffer between fetch and decode, with
// combinational field decode of the head entry. Empty or reset presents a NOP.
module if_id_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [XLEN-1:0] id_imm,
  output logic [2:0]      id_fmt,
  output logic            id_rs1_used,
  output logic            id_rs2_used,
  output logic            id_rd_wr,
  output logic            id_illegal
);

  typedef enum logic [2:0] {
    FmtR   = 3'd0,
    FmtI   = 3'd1,
    FmtS   = 3'd2,
    FmtB   = 3'd3,
    FmtU   = 3'd4,
    FmtJ   = 3'd5,
    FmtIll = 3'd7
  } fmt_e;

  logic            main_valid_q, main_valid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d;
  logic [31:0]     main_instr_q, main_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  logic accept;
  logic pop;

  // Ready depends only on registered skid occupancy, never on id_ready.
  assign if_ready = !skid_valid_q;
  assign id_valid = main_valid_q;
  assign id_pc    = main_pc_q;
  assign accept   = if_valid && if_ready;
  assign pop      = main_valid_q && id_ready;

  // Next-state: FIFO order, skid drains into main before new input is taken.
  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_pc_d    = if_pc;
          main_instr_d = if_instr;
        end
      end
    end else if (accept) begin
      // Main stays occupied and skid is empty (if_ready implies it).
      skid_valid_d = 1'b1;
      skid_pc_d    = if_pc;
      skid_instr_d = if_instr;
    end
  end

  // State registers with synchronous reset to an empty NOP-holding stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  logic [31:0] instr;
  fmt_e        fmt;
  logic [31:0] imm32;

  // Decode of the head entry; an empty stage decodes as NOP.
  always_comb begin
    instr       = main_valid_q ? main_instr_q : NOP_INSTR;
    fmt         = FmtIll;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd_wr    = 1'b0;
    imm32       = '0;
    unique case (instr[6:0])
      7'b0110011: fmt = FmtR;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FmtI;
      7'b0100011: fmt = FmtS;
      7'b1100011: fmt = FmtB;
      7'b0110111, 7'b0010111: fmt = FmtU;
      7'b1101111: fmt = FmtJ;
      default: fmt = FmtIll;
    endcase
    // Every legal opcode already has [1:0]==2'b11; the check is kept explicit.
    if (instr[1:0] != 2'b11) fmt = FmtIll;
    unique case (fmt)
      FmtR: begin
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
        id_rd_wr    = 1'b1;
      end
      FmtI: begin
        id_rs1_used = 1'b1;
        id_rd_wr    = 1'b1;
        imm32       = {{20{instr[31]}}, instr[31:20]};
      end
      FmtS: begin
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
        imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      FmtB: begin
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
        imm32       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      FmtU: begin
        id_rd_wr = 1'b1;
        imm32    = {instr[31:12], 12'b0};
      end
      FmtJ: begin
        id_rd_wr = 1'b1;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Field gating: unused fields read as 0 so ID never sees stale register numbers.
  always_comb begin
    id_instr   = instr;
    id_opcode  = instr[6:0];
    id_fmt     = fmt;
    id_illegal = (fmt == FmtIll);
    id_rd      = id_rd_wr ? instr[11:7] : 5'd0;
    id_rs1     = id_rs1_used ? instr[19:15] : 5'd0;
    id_rs2     = id_rs2_used ? instr[24:20] : 5'd0;
    id_funct3  = (fmt == FmtR || fmt == FmtI || fmt == FmtS || fmt == FmtB) ?
                 instr[14:12] : 3'd0;
    id_funct7  = (fmt == FmtR) ? instr[31:25] : 7'd0;
    id_imm     = XLEN'($signed(imm32));
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus a randomized run against a
// queue-based model of the stage and a table-driven decode reference.
module tb_if_id_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic [31:0] if_pc, if_instr;

  logic        if_ready, id_valid, id_rs1_used, id_rs2_used, id_rd_wr, id_illegal;
  logic [31:0] id_pc, id_instr, id_imm;
  logic [6:0]  id_opcode, id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3, id_fmt;

  logic        b_if_ready, b_id_valid, b_rs1_used, b_rs2_used, b_rd_wr, b_illegal;
  logic [31:0] b_pc, b_instr;
  logic [63:0] b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_funct3, b_fmt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t mq[$];

  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       rs1u, rs2u, rdw, ill;
    logic [6:0] opc;
  } dec_t;

  if_id_stage #(.XLEN(32), .PC_W(32), .NOP_INSTR(Nop)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_imm(id_imm), .id_fmt(id_fmt), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rd_wr(id_rd_wr), .id_illegal(id_illegal)
  );

  if_id_stage #(.XLEN(64), .PC_W(32), .NOP_INSTR(Nop)) dut64 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(b_if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .flush(flush), .id_valid(b_id_valid), .id_ready(id_ready),
    .id_pc(b_pc), .id_instr(b_instr), .id_opcode(b_opcode), .id_rd(b_rd),
    .id_rs1(b_rs1), .id_rs2(b_rs2), .id_funct3(b_funct3), .id_funct7(b_funct7),
    .id_imm(b_imm), .id_fmt(b_fmt), .id_rs1_used(b_rs1_used),
    .id_rs2_used(b_rs2_used), .id_rd_wr(b_rd_wr), .id_illegal(b_illegal)
  );

  always #5 clk = ~clk;

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.opc = w[6:0];
    case (w[6:0])
      7'b0110011: begin d.fmt = 3'd0; d.rs1u = 1; d.rs2u = 1; d.rdw = 1; end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                  begin d.fmt = 3'd1; d.rs1u = 1; d.rdw = 1; end
      7'b0100011: begin d.fmt = 3'd2; d.rs1u = 1; d.rs2u = 1; end
      7'b1100011: begin d.fmt = 3'd3; d.rs1u = 1; d.rs2u = 1; end
      7'b0110111, 7'b0010111: begin d.fmt = 3'd4; d.rdw = 1; end
      7'b1101111: begin d.fmt = 3'd5; d.rdw = 1; end
      default:    begin d.fmt = 3'd7; d.ill = 1; end
    endcase
    if (d.rdw) d.rd = w[11:7];
    if (d.rs1u) d.rs1 = w[19:15];
    if (d.rs2u) d.rs2 = w[24:20];
    if (d.fmt <= 3'd3) d.f3 = w[14:12];
    if (d.fmt == 3'd0) d.f7 = w[31:25];
    return d;
  endfunction

  // Immediate as a signed integer value; the DUT output must equal it mod 2^XLEN.
  function automatic longint ref_imm(input logic [31:0] w);
    dec_t d;
    d = ref_decode(w);
    case (d.fmt)
      3'd1: return longint'($signed(w[31:20]));
      3'd2: return longint'($signed({w[31:25], w[11:7]}));
      3'd3: return longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd4: return longint'($signed(w[31:12])) * 4096;
      3'd5: return longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    bit rdy, acc, pop;
    rdy = mq.size() < 2;
    acc = if_valid && rdy;
    pop = (mq.size() > 0) && id_ready;
    if (rst || flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: if_pc, instr: if_instr});
    end
  endtask

  // Advance one clock; model follows the edge, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; if_valid = 0; flush = 0; id_ready = 0; if_pc = '0; if_instr = '0;
    repeat (3) tick();
    rst = 0;
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL reset_id_valid got %0b want 0", id_valid); end
    checks++; if (if_ready !== 1'b1) begin errors++;
      $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    checks++; if (id_instr !== Nop) begin errors++;
      $display("FAIL reset_id_instr got %h want %h", id_instr, Nop); end
    checks++; if (id_imm !== 32'd0 || b_imm !== 64'd0) begin errors++;
      $display("FAIL reset_id_imm got %h/%h want 0", id_imm, b_imm); end
    checks++; if ({id_fmt, id_rd, id_rs1, id_illegal} !== {3'd1, 5'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_decode got fmt=%0d rd=%0d rs1=%0d ill=%0b want 1/0/0/0",
               id_fmt, id_rd, id_rs1, id_illegal); end
  endtask

  task automatic test_single_accept();
    id_ready = 1; if_valid = 1; if_pc = 32'h100; if_instr = 32'hFFF0_0093;
    tick();
    if_valid = 0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++;
      $display("FAIL single_head got v=%0b pc=%h want 1/100", id_valid, id_pc); end
    checks++; if ({id_fmt, id_rd, id_rs1} !== {3'd1, 5'd1, 5'd0}) begin errors++;
      $display("FAIL single_fields got fmt=%0d rd=%0d rs1=%0d want 1/1/0",
               id_fmt, id_rd, id_rs1); end
    checks++; if (id_imm !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL single_imm32 got %h want ffffffff", id_imm); end
    checks++; if (b_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
      $display("FAIL single_imm64 got %h want ffffffffffffffff", b_imm); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL single_drain got %0b want 0", id_valid); end
  endtask

  task automatic test_back_to_back();
    id_ready = 0; if_valid = 1; if_pc = 32'h0; if_instr = 32'h0010_0113;
    tick();
    if_pc = 32'h4; if_instr = 32'h0020_0193;
    tick();
    checks++; if (if_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_full_ready got %0b want 0", if_ready); end
    if_pc = 32'h8; if_instr = 32'h0030_0213;
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || if_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_hold got v=%0b pc=%h rdy=%0b want 1/0/0", id_valid, id_pc, if_ready);
    end
    id_ready = 1;
    tick();
    checks++; if (id_pc !== 32'h4 || id_instr !== 32'h0020_0193 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop1 got pc=%h instr=%h rdy=%0b want 4/00200193/1",
               id_pc, id_instr, if_ready); end
    tick();
    if_valid = 0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h0030_0213) begin
      errors++;
      $display("FAIL b2b_pop2 got v=%0b pc=%h instr=%h want 1/8/00300213",
               id_valid, id_pc, id_instr); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_empty got %0b want 0", id_valid); end
  endtask

  task automatic test_flush();
    id_ready = 0; if_valid = 1; if_pc = 32'h200; if_instr = 32'h0000_0033;
    tick();
    if_pc = 32'h204;
    tick();
    if_pc = 32'h208; if_instr = 32'h00A0_0513; flush = 1;
    tick();
    flush = 0; if_valid = 0;
    checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin errors++;
      $display("FAIL flush_full got v=%0b rdy=%0b want 0/1", id_valid, if_ready); end
    id_ready = 1;
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL flush_no_leak got v=%0b pc=%h want 0", id_valid, id_pc); end
    // One entry held, ready high: the input offered alongside flush is dropped.
    id_ready = 0; if_valid = 1; if_pc = 32'h300;
    tick();
    if_pc = 32'h304; flush = 1; id_ready = 1;
    tick();
    flush = 0; if_valid = 0;
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL flush_drop_input got v=%0b pc=%h want 0", id_valid, id_pc); end
    tick();
    checks++; if (id_valid !== 1'b0) begin errors++;
      $display("FAIL flush_drop_input_late got v=%0b pc=%h want 0", id_valid, id_pc); end
  endtask

  task automatic test_decode();
    logic [31:0] words [3];
    logic [2:0]  fmts  [3];
    logic [31:0] imms  [3];
    logic [4:0]  rds   [3];
    words = '{32'hFE00_0EE3, 32'h0010_00EF, 32'h1234_52B7};
    fmts  = '{3'd3, 3'd5, 3'd4};
    imms  = '{32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000};
    rds   = '{5'd0, 5'd1, 5'd5};
    for (int i = 0; i < 3; i++) begin
      id_ready = 1; if_valid = 1; if_pc = 32'h400 + 32'(i * 4); if_instr = words[i];
      tick();
      if_valid = 0;
      checks++;
      if (id_fmt !== fmts[i] || id_imm !== imms[i] || id_rd !== rds[i]) begin errors++;
        $display("FAIL decode_%h got fmt=%0d imm=%h rd=%0d want %0d/%h/%0d", words[i],
                 id_fmt, id_imm, id_rd, fmts[i], imms[i], rds[i]); end
      if (i == 0) begin
        checks++; if ({id_rs1_used, id_rs2_used, id_rd_wr} !== 3'b110) begin errors++;
          $display("FAIL decode_branch_usage got %b want 110",
                   {id_rs1_used, id_rs2_used, id_rd_wr}); end
      end
      tick();
    end
  endtask

  task automatic test_illegal_and_rst();
    id_ready = 0; if_valid = 1; if_pc = 32'h500; if_instr = 32'h0000_0000;
    tick();
    checks++;
    if ({id_illegal, id_fmt, id_rs1_used, id_rs2_used, id_rd_wr} !== {1'b1, 3'd7, 3'b000} ||
        id_imm !== 32'd0) begin errors++;
      $display("FAIL illegal_zero got ill=%0b fmt=%0d use=%b imm=%h want 1/7/000/0",
               id_illegal, id_fmt, {id_rs1_used, id_rs2_used, id_rd_wr}, id_imm); end
    if_pc = 32'h504; if_instr = 32'h0000_0013;
    tick();
    if_valid = 0; rst = 1;
    tick();
    rst = 0;
    checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_instr !== Nop) begin errors++;
      $display("FAIL rst_full got v=%0b rdy=%0b instr=%h want 0/1/%h",
               id_valid, if_ready, id_instr, Nop); end
  endtask

  task automatic test_random();
    logic [6:0] ops [12];
    dec_t        ed;
    logic [63:0] eimm;
    logic [31:0] einstr;
    bit          ev;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h7F, 7'h0B};
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      if_valid = ($urandom_range(0, 2) != 0);
      id_ready = ($urandom_range(0, 2) != 0);
      if_pc    = $urandom & 32'hFFFF_FFFC;
      if_instr = $urandom;
      if_instr[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) if_instr[1:0] = 2'($urandom_range(0, 2));
      tick();
      ev     = mq.size() > 0;
      einstr = ev ? mq[0].instr : Nop;
      ed     = ref_decode(einstr);
      eimm   = 64'(ref_imm(einstr));
      checks++;
      if (id_valid !== ev || if_ready !== (mq.size() < 2)) begin errors++;
        $display("FAIL rand_handshake n=%0d got v=%0b rdy=%0b want %0b/%0b", n,
                 id_valid, if_ready, ev, mq.size() < 2); end
      checks++;
      if (id_instr !== einstr || (ev && id_pc !== mq[0].pc)) begin errors++;
        $display("FAIL rand_head n=%0d got %h@%h want %h", n, id_instr, id_pc, einstr); end
      checks++;
      if ({id_fmt, id_rd, id_rs1, id_rs2, id_funct3, id_funct7, id_rs1_used, id_rs2_used,
           id_rd_wr, id_illegal, id_opcode} !== ed) begin errors++;
        $display("FAIL rand_decode n=%0d instr=%h got %h want %h", n, einstr,
                 {id_fmt, id_rd, id_rs1, id_rs2, id_funct3, id_funct7, id_rs1_used,
                  id_rs2_used, id_rd_wr, id_illegal, id_opcode}, ed); end
      checks++;
      if (id_imm !== eimm[31:0] || b_imm !== eimm) begin errors++;
        $display("FAIL rand_imm n=%0d instr=%h got %h/%h want %h", n, einstr,
                 id_imm, b_imm, eimm); end
    end
    rst = 0; flush = 0; if_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_accept();
    test_back_to_back();
    test_flush();
    test_decode();
    test_illegal_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
